dsp_sub_v2_pipe: RTL and testbench



---
 rtl/prim_dsp_pkg.sv | 39 +++
 rtl/dsp_pipe_ctrl.sv | 40 ++++
 rtl/dsp_sub_v2_pipe.sv | 91 +++++++++
 tb/tb_dsp_sub_v2_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prim_dsp_pkg.sv
// Shared DSP48E2 constants and a behavioural TWO24 ALU used by pipelined
// DSP primitives (add/sub lanes) built on a single slice.
package prim_dsp_pkg;

  localparam int DSP_LANE24 = 24;
  localparam int DSP_A_W    = 30;
  localparam int DSP_B_W    = 18;
  localparam int DSP_P_W    = 48;
  localparam int DSP_D_W    = 27;

  localparam logic [3:0] DSP_ALUMODE_SUB      = 4'b0011;
  localparam logic [8:0] DSP_OPMODE_C_PLUS_AB = 9'b000110011;

  // Post-adder in TWO24 SIMD mode: each 24-bit lane is independent, so no
  // carry/borrow crosses bit 24. Only the X = A:B, Z = C selection is modelled.
  function automatic logic [DSP_P_W-1:0] dsp_two24_alu(
    input logic [3:0]         alumode,
    input logic [8:0]         opmode,
    input logic [DSP_P_W-1:0] ab,
    input logic [DSP_P_W-1:0] c
  );
    logic [DSP_P_W-1:0] x;
    logic [DSP_P_W-1:0] zz;
    logic [DSP_P_W-1:0] p;
    logic               wy_zero;
    wy_zero = (opmode[8:7] == 2'b00) && (opmode[3:2] == 2'b00);
    x  = (opmode[1:0] == 2'b11) ? ab : '0;
    zz = (opmode[6:4] == 3'b011) ? c : '0;
    p  = '0;
    for (int l = 0; l < 2; l++) begin
      if (alumode == DSP_ALUMODE_SUB)
        p[l*DSP_LANE24 +: DSP_LANE24] = zz[l*DSP_LANE24 +: DSP_LANE24] - x[l*DSP_LANE24 +: DSP_LANE24];
      else
        p[l*DSP_LANE24 +: DSP_LANE24] = zz[l*DSP_LANE24 +: DSP_LANE24] + x[l*DSP_LANE24 +: DSP_LANE24];
    end
    return wy_zero ? p : '0;
  endfunction

endpackage

// File: rtl/dsp_pipe_ctrl.sv
// Valid/stall controller for a fixed-depth pipeline that freezes as a whole
// when its last stage holds a result the consumer will not take.
import prim_dsp_pkg::*;

module dsp_pipe_ctrl #(
  parameter int depth = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             advance,
  output logic             in_ready,
  output logic [depth-1:0] stage_valid
);

  if (depth < 2) begin : g_depth_check
    $error("dsp_pipe_ctrl: depth must be at least 2");
  end

  logic [depth-1:0] valid_q;
  logic [depth-1:0] valid_d;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is a pure function of out_ready and the last stage, no register.
  always_comb begin
    advance = !(valid_q[depth-1] && !out_ready);
    valid_d = valid_q;
    if (advance) valid_d = {valid_q[depth-2:0], in_valid};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  assign in_ready    = advance;
  assign stage_valid = valid_q;

endmodule

// File: rtl/dsp_sub_v2_pipe.sv
// Two-lane SIMD subtractor (y = a - b, z = c - d) on one DSP48E2 in TWO24
// mode, with input and P registers and a valid/ready backpressure pipe.
import prim_dsp_pkg::*;

module dsp_sub_v2_pipe #(
  parameter int width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [width-1:0] c,
  input  logic [width-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] y,
  output logic [width-1:0] z,
  output logic             borrow_y,
  output logic             borrow_z
);

  if (width < 1 || width > 23) begin : g_width_check
    $error("dsp_sub_v2_pipe: width must be in 1..23");
  end

  logic       advance;
  logic [1:0] stage_valid;

  dsp_pipe_ctrl #(.depth(2)) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .advance     (advance),
    .in_ready    (in_ready),
    .stage_valid (stage_valid)
  );

  // Minuends go to C, subtrahends to A:B; zero-extension leaves bit `width`
  // of each lane as the borrow.
  logic [DSP_P_W-1:0] c_pack;
  logic [DSP_P_W-1:0] ab_pack;
  assign c_pack  = {{(DSP_LANE24-width){1'b0}}, c, {(DSP_LANE24-width){1'b0}}, a};
  assign ab_pack = {{(DSP_LANE24-width){1'b0}}, d, {(DSP_LANE24-width){1'b0}}, b};

  logic [DSP_A_W-1:0] a_reg_q, a_reg_d;
  logic [DSP_B_W-1:0] b_reg_q, b_reg_d;
  logic [DSP_P_W-1:0] c_reg_q, c_reg_d;
  logic [DSP_P_W-1:0] p_q,     p_d;

  always_comb begin
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    c_reg_d = c_reg_q;
    p_d     = p_q;
    if (advance) begin
      a_reg_d = ab_pack[DSP_P_W-1:DSP_B_W];
      b_reg_d = ab_pack[DSP_B_W-1:0];
      c_reg_d = c_pack;
      p_d     = dsp_two24_alu(DSP_ALUMODE_SUB, DSP_OPMODE_C_PLUS_AB, {a_reg_q, b_reg_q}, c_reg_q);
    end
  end

  // Slice registers (A2/B2/C/P) with their synchronous RST pins; results in
  // flight are discarded on reset because the valid bits clear asynchronously.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg_q <= '0;
      b_reg_q <= '0;
      c_reg_q <= '0;
      p_q     <= '0;
    end else begin
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      c_reg_q <= c_reg_d;
      p_q     <= p_d;
    end
  end

  assign out_valid = stage_valid[1];
  assign y         = p_q[width-1:0] & {width{stage_valid[1]}};
  assign borrow_y  = p_q[width] & stage_valid[1];
  assign z         = p_q[DSP_LANE24 +: width] & {width{stage_valid[1]}};
  assign borrow_z  = p_q[DSP_LANE24 + width] & stage_valid[1];

  logic unused_bits;
  assign unused_bits = ^{p_q, stage_valid[0]};

endmodule

// File: tb/tb_dsp_sub_v2_pipe.sv
// Directed-plus-random bench for dsp_sub_v2_pipe against a transaction-level
// model: items enter a queue and become visible two pipe advances later.
module tb_dsp_sub_v2_pipe;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y, z;
  logic         borrow_y, borrow_z;

  int checks = 0;
  int errors = 0;

  logic [4*W-1:0] exp_q[$];
  int             tick_q[$];
  int             pipe_tick = 0;

  always #5 clock = ~clock;

  dsp_sub_v2_pipe #(.width(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .z         (z),
    .borrow_y  (borrow_y),
    .borrow_z  (borrow_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ic, input logic [W-1:0] id, input logic ordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    c         = ic;
    d         = id;
    out_ready = ordy;
  endtask

  task automatic drive_rand(input logic iv, input logic ordy);
    drive(iv, W'($urandom), W'($urandom), W'($urandom), W'($urandom), ordy);
  endtask

  function automatic logic model_out_valid();
    return (exp_q.size() > 0) && (tick_q[0] + 2 == pipe_tick);
  endfunction

  function automatic logic [W:0] sub_ref(input logic [W-1:0] m, input logic [W-1:0] s);
    int diff;
    logic [31:0] dv;
    diff = int'(m) - int'(s);
    if (diff < 0) diff = diff + (1 << W);
    dv = diff;
    return {(m < s), dv[W-1:0]};
  endfunction

  task automatic check_outputs(input string ctx);
    logic         ov;
    logic [W-1:0] ea, eb, ec, ed;
    logic [W:0]   ry, rz;
    ov = model_out_valid();
    ry = '0;
    rz = '0;
    if (ov) begin
      {ea, eb, ec, ed} = exp_q[0];
      ry = sub_ref(ea, eb);
      rz = sub_ref(ec, ed);
    end
    chk({ctx, " out_valid"}, out_valid, ov);
    chk({ctx, " in_ready"}, in_ready, !(ov && !out_ready));
    chk({ctx, " y"}, y, ry[W-1:0]);
    chk({ctx, " borrow_y"}, borrow_y, ry[W]);
    chk({ctx, " z"}, z, rz[W-1:0]);
    chk({ctx, " borrow_z"}, borrow_z, rz[W]);
  endtask

  // Check just after the falling edge, then let the rising edge happen and
  // update the model with the inputs that were present at that edge.
  task automatic cycle(input string ctx);
    logic ov;
    #1;
    check_outputs(ctx);
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      tick_q.delete();
    end else begin
      ov = model_out_valid();
      if (!(ov && !out_ready)) begin
        if (ov) begin
          void'(exp_q.pop_front());
          void'(tick_q.pop_front());
        end
        if (in_valid) begin
          exp_q.push_back({a, b, c, d});
          tick_q.push_back(pipe_tick);
        end
        pipe_tick++;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    // Reset with garbage on the inputs and in_valid high.
    reset = 1'b1;
    drive_rand(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'($urandom));
      cycle("reset");
    end
    reset = 1'b0;

    // Basic: first accept on the first edge after release.
    drive(1'b1, 16'd100, 16'd30, 16'd5, 16'd7, 1'b1);
    cycle("basic_acc");
    drive(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    cycle("basic_gap");
    #1;
    chk("basic out_valid", out_valid, 1'b1);
    chk("basic y", y, 16'd70);
    chk("basic borrow_y", borrow_y, 1'b0);
    chk("basic z", z, 16'hFFFE);
    chk("basic borrow_z", borrow_z, 1'b1);

    // Lane isolation: lane 0 borrows, lane 1 must not see it.
    drive(1'b1, 16'd0, 16'd1, 16'hFFFF, 16'd0, 1'b1);
    cycle("lane_acc");
    drive(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    cycle("lane_gap");
    #1;
    chk("lane y", y, 16'hFFFF);
    chk("lane borrow_y", borrow_y, 1'b1);
    chk("lane z", z, 16'hFFFF);
    chk("lane borrow_z", borrow_z, 1'b0);

    // Streaming: 8 back-to-back vectors, then drain.
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1, 1'b1);
      cycle("stream");
    end
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle("stream_drain");
    end

    // Backpressure: fill both stages, then stall three cycles.
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b1);
      cycle("bp_fill");
    end
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b0);
      #1;
      chk("bp in_ready", in_ready, 1'b0);
      cycle("bp_stall");
    end
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b1);
      cycle("bp_release");
    end
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle("bp_drain");
    end

    // Mid-stream reset with both stages full.
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b1);
      cycle("mr_fill");
    end
    reset = 1'b1;
    exp_q.delete();
    tick_q.delete();
    #1;
    chk("mr async out_valid", out_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b1);
      cycle("mr_hold");
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle("mr_idle");
    end
    drive_rand(1'b1, 1'b1);
    cycle("mr_new");
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle("mr_drain");
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 200; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      cycle("random");
    end
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle("final_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
